// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the data-memory port between the CPU MEM stage
// and a debug/loader port, with round-robin grant and an access timeout.
module dmem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_stall_o,
  output logic              cpu_err_o,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              dbg_ack_o,
  output logic              dbg_err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CMAX = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    BUSY_C,
    BUSY_D,
    DONE_C,
    DONE_D
  } state_t;

  state_t            state, state_nx;
  logic              last_d, last_d_nx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic              lat_we, lat_we_nx;
  logic [ADDR_W-1:0] lat_addr, lat_addr_nx;
  logic [DATA_W-1:0] lat_wdata, lat_wdata_nx;
  logic [DATA_W-1:0] crd, crd_nx;
  logic [DATA_W-1:0] drd, drd_nx;
  logic              err, err_nx;
  logic              busy;
  logic              pick_c;
  logic              pick_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      last_d    <= 1'b1;
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      crd       <= '0;
      drd       <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_nx;
      last_d    <= last_d_nx;
      cnt       <= cnt_nx;
      lat_we    <= lat_we_nx;
      lat_addr  <= lat_addr_nx;
      lat_wdata <= lat_wdata_nx;
      crd       <= crd_nx;
      drd       <= drd_nx;
      err       <= err_nx;
    end
  end

  // Contention goes to whichever port was not granted last.
  assign pick_c = cpu_req_i & (~dbg_req_i | last_d);
  assign pick_d = dbg_req_i & (~cpu_req_i | ~last_d);

  always_comb begin
    state_nx     = state;
    last_d_nx    = last_d;
    cnt_nx       = cnt;
    lat_we_nx    = lat_we;
    lat_addr_nx  = lat_addr;
    lat_wdata_nx = lat_wdata;
    crd_nx       = crd;
    drd_nx       = drd;
    err_nx       = err;
    unique case (state)
      IDLE: begin
        if (pick_c) begin
          state_nx     = BUSY_C;
          last_d_nx    = 1'b0;
          cnt_nx       = '0;
          err_nx       = 1'b0;
          lat_we_nx    = cpu_we_i;
          lat_addr_nx  = cpu_addr_i;
          lat_wdata_nx = cpu_wdata_i;
        end else if (pick_d) begin
          state_nx     = BUSY_D;
          last_d_nx    = 1'b1;
          cnt_nx       = '0;
          err_nx       = 1'b0;
          lat_we_nx    = dbg_we_i;
          lat_addr_nx  = dbg_addr_i;
          lat_wdata_nx = dbg_wdata_i;
        end
      end
      BUSY_C, BUSY_D: begin
        if (mem_ack_i) begin
          err_nx = 1'b0;
          if (state == BUSY_C) begin
            state_nx = DONE_C;
            if (!lat_we) crd_nx = mem_rdata_i;
          end else begin
            state_nx = DONE_D;
            if (!lat_we) drd_nx = mem_rdata_i;
          end
        end else if (cnt == CMAX) begin
          err_nx = 1'b1;
          if (state == BUSY_C) begin
            state_nx = DONE_C;
            crd_nx   = '0;
          end else begin
            state_nx = DONE_D;
            drd_nx   = '0;
          end
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      DONE_C, DONE_D: state_nx = IDLE;
      default:        state_nx = IDLE;
    endcase
  end

  assign busy        = (state == BUSY_C) | (state == BUSY_D);
  assign mem_req_o   = busy;
  assign mem_we_o    = busy & lat_we;
  assign mem_addr_o  = busy ? lat_addr : '0;
  assign mem_wdata_o = busy ? lat_wdata : '0;

  assign cpu_rdata_o = crd;
  assign cpu_stall_o = cpu_req_i & (state != DONE_C);
  assign cpu_err_o   = (state == DONE_C) & err;
  assign dbg_rdata_o = drd;
  assign dbg_ack_o   = (state == DONE_D);
  assign dbg_err_o   = (state == DONE_D) & err;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: randomized scenarios against a transaction-level
// memory model and round-robin grant model.
module tb_dmem_port_arbiter;

  localparam int TO = 16;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cpu_req_i = 1'b0;
  logic        cpu_we_i = 1'b0;
  logic [31:0] cpu_addr_i = '0;
  logic [31:0] cpu_wdata_i = '0;
  logic [31:0] cpu_rdata_o;
  logic        cpu_stall_o;
  logic        cpu_err_o;
  logic        dbg_req_i = 1'b0;
  logic        dbg_we_i = 1'b0;
  logic [31:0] dbg_addr_i = '0;
  logic [31:0] dbg_wdata_i = '0;
  logic [31:0] dbg_rdata_o;
  logic        dbg_ack_o;
  logic        dbg_err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;

  dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i),
    .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i),
    .cpu_rdata_o(cpu_rdata_o), .cpu_stall_o(cpu_stall_o),
    .cpu_err_o(cpu_err_o),
    .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i),
    .dbg_addr_i(dbg_addr_i), .dbg_wdata_i(dbg_wdata_i),
    .dbg_rdata_o(dbg_rdata_o), .dbg_ack_o(dbg_ack_o),
    .dbg_err_o(dbg_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
  );

  initial forever #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int wait_cfg = 0;
  bit hang = 1'b0;
  int run = 0;
  int last_run = 0;
  int n_dack = 0;
  logic [31:0] log_addr[$];
  logic        log_we[$];
  logic [31:0] log_wd[$];
  logic [31:0] mem_arr [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  bit          model_last_d = 1'b1;
  logic [31:0] exp_cpu_rd = '0;
  logic [31:0] exp_dbg_rd = '0;

  always @(posedge clk_i) cyc <= cyc + 1;
  always @(negedge clk_i) if (dbg_ack_o) n_dack = n_dack + 1;

  // Memory responder: acks after wait_cfg busy cycles, garbage otherwise.
  initial begin
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(negedge clk_i);
      mem_ack_i = 1'b0;
      if (mem_req_o) begin
        if (!hang && run == wait_cfg) begin
          mem_ack_i = 1'b1;
          log_addr.push_back(mem_addr_o);
          log_we.push_back(mem_we_o);
          log_wd.push_back(mem_wdata_o);
          if (mem_we_o) begin
            mem_arr[mem_addr_o] = mem_wdata_o;
            mem_rdata_i = $urandom;
          end else begin
            mem_rdata_i = mem_arr.exists(mem_addr_o) ?
                          mem_arr[mem_addr_o] : '0;
          end
        end else begin
          mem_rdata_i = $urandom;
        end
        run++;
      end else begin
        if (run > 0) last_run = run;
        run = 0;
        mem_rdata_i = $urandom;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic logic [31:0] ref_rd(logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : '0;
  endfunction

  task automatic clr_log();
    log_addr.delete();
    log_we.delete();
    log_wd.delete();
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    mem_arr[a] = v;
    ref_mem[a] = v;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    cpu_req_i = 1'b0;
    dbg_req_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    model_last_d = 1'b1;
    exp_cpu_rd = '0;
    exp_dbg_rd = '0;
  endtask

  task automatic cpu_access(input logic we, input logic [31:0] a,
                            input logic [31:0] d,
                            output logic [31:0] rd, output logic er,
                            output int st, output int dc, output bit ok);
    @(negedge clk_i);
    cpu_req_i = 1'b1;
    cpu_we_i = we;
    cpu_addr_i = a;
    cpu_wdata_i = d;
    st = 0;
    dc = -1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (!cpu_stall_o) begin
        ok = 1'b1;
        dc = cyc;
        break;
      end
      st++;
      @(negedge clk_i);
    end
    rd = cpu_rdata_o;
    er = cpu_err_o;
    cpu_req_i = 1'b0;
  endtask

  task automatic dbg_access(input logic we, input logic [31:0] a,
                            input logic [31:0] d,
                            output logic [31:0] rd, output logic er,
                            output int lat, output int dc, output bit ok);
    @(negedge clk_i);
    dbg_req_i = 1'b1;
    dbg_we_i = we;
    dbg_addr_i = a;
    dbg_wdata_i = d;
    lat = 0;
    dc = -1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (dbg_ack_o) begin
        ok = 1'b1;
        dc = cyc;
        break;
      end
      lat++;
      @(negedge clk_i);
    end
    rd = dbg_rdata_o;
    er = dbg_err_o;
    dbg_req_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rst_i = 1'b1;
    #1;
    n_cmp++;
    if (mem_req_o !== 1'b0 || mem_we_o !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_memreq got %b/%b exp 0/0", mem_req_o, mem_we_o);
    end
    n_cmp++;
    if (mem_addr_o !== '0 || mem_wdata_o !== '0) begin
      n_bad++;
      $display("FAIL rst_memaddr got %h/%h exp 0", mem_addr_o, mem_wdata_o);
    end
    n_cmp++;
    if ({dbg_ack_o, dbg_err_o, cpu_err_o, cpu_stall_o} !== 4'b0) begin
      n_bad++;
      $display("FAIL rst_flags got %b exp 0000",
               {dbg_ack_o, dbg_err_o, cpu_err_o, cpu_stall_o});
    end
    n_cmp++;
    if (cpu_rdata_o !== '0 || dbg_rdata_o !== '0) begin
      n_bad++;
      $display("FAIL rst_rdata got %h/%h exp 0", cpu_rdata_o, dbg_rdata_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    n_cmp++;
    if (mem_req_o !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_idle_req got %b exp 0", mem_req_o);
    end
  endtask

  task automatic test_cpu_read();
    logic [31:0] rd;
    logic er;
    int st, dc;
    bit ok;
    preload(32'h0, 32'd5);
    wait_cfg = 0;
    clr_log();
    cpu_access(1'b0, 32'h0, 32'h0, rd, er, st, dc, ok);
    exp_cpu_rd = ref_rd(32'h0);
    model_last_d = 1'b0;
    n_cmp++;
    if (st !== 2) begin
      n_bad++;
      $display("FAIL t1_stall got %0d exp 2", st);
    end
    n_cmp++;
    if (rd !== exp_cpu_rd || er !== 1'b0) begin
      n_bad++;
      $display("FAIL t1_rdata got %h err %b exp %h err 0", rd, er, exp_cpu_rd);
    end
    n_cmp++;
    if (log_addr.size() != 1 || log_addr[0] !== 32'h0) begin
      n_bad++;
      $display("FAIL t1_addr got n=%0d exp 1 access at 0", log_addr.size());
    end
  endtask

  task automatic test_simultaneous();
    logic [31:0] crd, drd, v;
    logic cer, der;
    int cst, dlat, cdc, ddc;
    bit cok, dok;
    do_reset();
    v = $urandom;
    preload(32'h8, v);
    wait_cfg = 0;
    clr_log();
    fork
      cpu_access(1'b1, 32'h4, 32'd8, crd, cer, cst, cdc, cok);
      dbg_access(1'b0, 32'h8, 32'h0, drd, der, dlat, ddc, dok);
    join
    ref_mem[32'h4] = 32'd8;
    exp_dbg_rd = ref_rd(32'h8);
    model_last_d = 1'b1;
    n_cmp++;
    if (!cok || cst !== 2) begin
      n_bad++;
      $display("FAIL t2_cstall got %0d ok %b exp 2", cst, cok);
    end
    n_cmp++;
    if (!dok || ddc - cdc !== 3) begin
      n_bad++;
      $display("FAIL t2_ackgap got %0d exp 3", ddc - cdc);
    end
    n_cmp++;
    if (drd !== exp_dbg_rd || der !== 1'b0) begin
      n_bad++;
      $display("FAIL t2_drd got %h err %b exp %h", drd, der, exp_dbg_rd);
    end
    n_cmp++;
    if (crd !== exp_cpu_rd) begin
      n_bad++;
      $display("FAIL t2_cwr_rdata got %h exp %h", crd, exp_cpu_rd);
    end
    n_cmp++;
    if (log_addr.size() != 2 || log_addr[0] !== 32'h4 ||
        log_we[0] !== 1'b1 || log_wd[0] !== 32'd8 ||
        log_addr[1] !== 32'h8 || log_we[1] !== 1'b0) begin
      n_bad++;
      $display("FAIL t2_order got n=%0d a0=%h a1=%h exp 4,8",
               log_addr.size(), log_addr[0], log_addr[1]);
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] c0, c1, d0, d1, ca[2], da[2], exp_q[$];
    logic ce0, ce1, de0, de1;
    int s, l, x;
    bit k0, k1, k2, k3;
    for (int i = 0; i < 2; i++) begin
      ca[i] = 32'h100 + 32'(i * 4);
      da[i] = 32'h200 + 32'(i * 4);
      preload(ca[i], $urandom);
      preload(da[i], $urandom);
    end
    for (int i = 0; i < 2; i++) begin
      if (model_last_d) begin
        exp_q.push_back(ca[i]);
        exp_q.push_back(da[i]);
      end else begin
        exp_q.push_back(da[i]);
        exp_q.push_back(ca[i]);
      end
    end
    wait_cfg = $urandom_range(0, 2);
    clr_log();
    fork
      begin
        cpu_access(1'b0, ca[0], 32'h0, c0, ce0, s, x, k0);
        cpu_access(1'b0, ca[1], 32'h0, c1, ce1, s, x, k1);
      end
      begin
        dbg_access(1'b0, da[0], 32'h0, d0, de0, l, x, k2);
        dbg_access(1'b0, da[1], 32'h0, d1, de1, l, x, k3);
      end
    join
    model_last_d = (exp_q[3] == da[1]);
    exp_cpu_rd = ref_rd(ca[1]);
    exp_dbg_rd = ref_rd(da[1]);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (log_addr.size() != 4 || log_addr[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL t3_seq%0d got %h exp %h", i, log_addr[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (!(k0 && k1 && k2 && k3) || c0 !== ref_rd(ca[0]) ||
        d0 !== ref_rd(da[0]) || c1 !== exp_cpu_rd || d1 !== exp_dbg_rd) begin
      n_bad++;
      $display("FAIL t3_data got %h %h %h %h", c0, c1, d0, d1);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] rd;
    logic er;
    int st, dc;
    bit ok;
    hang = 1'b1;
    last_run = -1;
    clr_log();
    cpu_access(1'b0, 32'h10, 32'h0, rd, er, st, dc, ok);
    exp_cpu_rd = '0;
    model_last_d = 1'b0;
    n_cmp++;
    if (st !== TO + 1) begin
      n_bad++;
      $display("FAIL t4_stall got %0d exp %0d", st, TO + 1);
    end
    n_cmp++;
    if (last_run !== TO) begin
      n_bad++;
      $display("FAIL t4_reqlen got %0d exp %0d", last_run, TO);
    end
    n_cmp++;
    if (er !== 1'b1 || rd !== exp_cpu_rd) begin
      n_bad++;
      $display("FAIL t4_err got err %b rd %h exp 1 / 0", er, rd);
    end
    @(negedge clk_i);
    #1;
    n_cmp++;
    if (cpu_err_o !== 1'b0 || log_addr.size() != 0) begin
      n_bad++;
      $display("FAIL t4_pulse got %b n=%0d exp 0", cpu_err_o, log_addr.size());
    end
    hang = 1'b0;
  endtask

  task automatic test_wait_states();
    logic [31:0] rd;
    logic er;
    int st, dc;
    bit ok;
    preload(32'h20, $urandom);
    wait_cfg = 2;
    cpu_access(1'b0, 32'h20, 32'h0, rd, er, st, dc, ok);
    exp_cpu_rd = ref_rd(32'h20);
    model_last_d = 1'b0;
    n_cmp++;
    if (st !== 4) begin
      n_bad++;
      $display("FAIL t6_stall got %0d exp 4", st);
    end
    n_cmp++;
    if (rd !== exp_cpu_rd || er !== 1'b0) begin
      n_bad++;
      $display("FAIL t6_rdata got %h err %b exp %h", rd, er, exp_cpu_rd);
    end
    wait_cfg = 0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    logic er;
    int st, dc, snap;
    bit ok;
    wait_cfg = 5;
    @(negedge clk_i);
    dbg_req_i = 1'b1;
    dbg_we_i = 1'b0;
    dbg_addr_i = 32'h30;
    @(negedge clk_i);
    @(negedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    n_cmp++;
    if (mem_req_o !== 1'b0 || dbg_ack_o !== 1'b0) begin
      n_bad++;
      $display("FAIL t5_async got req %b ack %b exp 0/0", mem_req_o, dbg_ack_o);
    end
    snap = n_dack;
    dbg_req_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    model_last_d = 1'b1;
    exp_cpu_rd = '0;
    exp_dbg_rd = '0;
    repeat (4) @(negedge clk_i);
    n_cmp++;
    if (n_dack !== snap || cpu_rdata_o !== exp_cpu_rd) begin
      n_bad++;
      $display("FAIL t5_noack got acks %0d rd %h exp 0 / 0",
               n_dack - snap, cpu_rdata_o);
    end
    wait_cfg = 0;
    preload(32'h34, $urandom);
    cpu_access(1'b0, 32'h34, 32'h0, rd, er, st, dc, ok);
    exp_cpu_rd = ref_rd(32'h34);
    model_last_d = 1'b0;
    n_cmp++;
    if (st !== 2 || rd !== exp_cpu_rd || er !== 1'b0) begin
      n_bad++;
      $display("FAIL t5_after got st %0d rd %h exp 2 %h", st, rd, exp_cpu_rd);
    end
  endtask

  task automatic test_random();
    logic [31:0] cad, cwd, dad, dwd, crd, drd, first;
    logic cwe, dwe, cer, der;
    int mode, cst, dlat, cdc, ddc;
    bit c_on, d_on, c_first, cok, dok;
    for (int it = 0; it < 30; it++) begin
      mode = $urandom_range(0, 2);
      wait_cfg = $urandom_range(0, 3);
      cwe = 1'($urandom_range(0, 1));
      dwe = 1'($urandom_range(0, 1));
      cad = $urandom_range(0, 7) << 2;
      dad = $urandom_range(0, 7) << 2;
      cwd = $urandom;
      dwd = $urandom;
      c_on = (mode != 1);
      d_on = (mode != 0);
      c_first = !d_on || (c_on && model_last_d);
      for (int p = 0; p < 2; p++) begin
        if ((p == 0) == c_first) begin
          if (c_on) begin
            if (cwe) ref_mem[cad] = cwd;
            else exp_cpu_rd = ref_rd(cad);
          end
        end else if (d_on) begin
          if (dwe) ref_mem[dad] = dwd;
          else exp_dbg_rd = ref_rd(dad);
        end
      end
      first = c_first ? cad : dad;
      clr_log();
      fork
        if (c_on) cpu_access(cwe, cad, cwd, crd, cer, cst, cdc, cok);
        if (d_on) dbg_access(dwe, dad, dwd, drd, der, dlat, ddc, dok);
      join
      model_last_d = !c_first || (mode == 1);
      if (mode == 2) model_last_d = c_first;
      n_cmp++;
      if (log_addr.size() == 0 || log_addr[0] !== first) begin
        n_bad++;
        $display("FAIL rnd%0d_first got %h exp %h", it, log_addr[0], first);
      end
      if (c_on) begin
        n_cmp++;
        if (!cok || crd !== exp_cpu_rd || cer !== 1'b0) begin
          n_bad++;
          $display("FAIL rnd%0d_cpu got %h err %b exp %h", it, crd, cer,
                   exp_cpu_rd);
        end
      end
      if (d_on) begin
        n_cmp++;
        if (!dok || drd !== exp_dbg_rd || der !== 1'b0) begin
          n_bad++;
          $display("FAIL rnd%0d_dbg got %h err %b exp %h", it, drd, der,
                   exp_dbg_rd);
        end
      end
      if (mode == 0) begin
        n_cmp++;
        if (cst !== 2 + wait_cfg) begin
          n_bad++;
          $display("FAIL rnd%0d_cst got %0d exp %0d", it, cst, 2 + wait_cfg);
        end
      end
      if (mode == 1) begin
        n_cmp++;
        if (dlat !== 2 + wait_cfg) begin
          n_bad++;
          $display("FAIL rnd%0d_dlat got %0d exp %0d", it, dlat, 2 + wait_cfg);
        end
      end
    end
    wait_cfg = 0;
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_simultaneous();
    test_round_robin();
    test_timeout();
    test_wait_states();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge clk_i);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
